// File: rtl/temporizador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_pkg
// Description : Shared types and helpers for the temporizador_bcd microwave
//               countdown timer: FSM state encoding, BCD digit constants, a
//               packed M:SS time record and the BCD shift-in / decrement
//               helpers used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package temporizador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam logic [3:0] BCD_NINE = 4'd9;

    // Displayed time M:SS, one BCD digit per field.
    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '{mins: BCD_ZERO, sec_tens: BCD_ZERO, sec_ones: BCD_ZERO};

    // Keypad entry: digits scroll in from the right, the old minutes digit
    // falls off the left.
    function automatic bcd_time_t bcd_shift_in(input bcd_time_t t, input logic [3:0] d);
        bcd_time_t r;
        r.mins     = t.sec_tens;
        r.sec_tens = t.sec_ones;
        r.sec_ones = d;
        return r;
    endfunction

    // One-second BCD decrement with borrow through the seconds tens (0-5)
    // into the minutes digit. 0:00 is returned unchanged.
    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_ones != BCD_ZERO) begin
            r.sec_ones = t.sec_ones - 4'd1;
        end else if (t.sec_tens != BCD_ZERO) begin
            r.sec_ones = BCD_NINE;
            r.sec_tens = t.sec_tens - 4'd1;
        end else if (t.mins != BCD_ZERO) begin
            r.mins     = t.mins - 4'd1;
            r.sec_tens = BCD_FIVE;
            r.sec_ones = BCD_NINE;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_bcd_divisor_1hz.sv
`default_nettype none
// ============================================================================
// Module      : divisor_1hz
// Description : Prescaler dividing the system clock down to a one-cycle
//               1 Hz tick. Counts 0..CLK_HZ-1 while enabled, holds while
//               disabled, and is zeroed by a synchronous clear.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               en     - count enable (count holds when low)
//               clr    - synchronous clear to 0, dominates en
//               tick   - high for the cycle in which count = CLK_HZ-1
//                        while enabled; the count wraps to 0 on that edge
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_1hz #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/temporizador_bcd.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_bcd
// Description : Microwave countdown timer. Captures M:SS from keypad BCD
//               digits in IDLE, counts down once per second in RUN, pauses
//               on stop or door open, and parks at 0:00 in DONE until clear.
//               Optional completion buzzer is enabled by defining the macro
//               TEMPORIZADOR_BEEP_EN (beep held for BEEP_SECS seconds).
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               digit       - keypad BCD digit
//               digit_valid - one-cycle strobe qualifying digit
//               start       - start / resume pulse
//               stop        - pause pulse
//               clear       - cancel, back to IDLE at 0:00
//               door_closed - level, 1 = door shut
//               mins        - BCD minutes (0-9)
//               sec_tens    - BCD tens of seconds (0-5)
//               sec_ones    - BCD seconds (0-9)
//               heating     - magnetron enable, high only in RUN
//               done        - high in DONE
//               beep        - buzzer, 0 unless TEMPORIZADOR_BEEP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       heating,
    output logic       done,
    output logic       beep
);

    state_t    state;
    bcd_time_t tm;
    bcd_time_t tm_dec;

    logic tick;
    logic div_en;
    logic div_clr;
    logic time_is_zero;
    logic start_from_idle;
    logic digit_accept;

    always_comb begin
        tm_dec       = bcd_decrement(tm);
        time_is_zero = (tm == TIME_ZERO);
        // start only wins in IDLE if nothing of higher priority is present
        start_from_idle = (state == ST_IDLE) && !clear && !stop && start
                          && door_closed && !time_is_zero;
        // A digit is swallowed whenever start or stop is also present; a
        // current sec_ones above 5 would shift an illegal tens digit in.
        digit_accept = (state == ST_IDLE) && !stop && !start && digit_valid
                       && (digit <= BCD_NINE) && (tm.sec_ones <= BCD_FIVE);
    end

    // A fresh run always starts a full second; resume from PAUSE does not.
    assign div_clr = clear || start_from_idle;

`ifdef TEMPORIZADOR_BEEP_EN
    localparam int                BEEP_W    = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);

    logic              beep_q;
    logic [BEEP_W-1:0] beep_cnt;

    // The prescaler keeps ticking in DONE only while the buzzer is timing.
    assign div_en = (state == ST_RUN) || ((state == ST_DONE) && beep_q);
    assign beep   = beep_q;
`else
    // Folds to 0; written against BEEP_SECS so the parameter is consumed
    // in this build as well.
    localparam logic BEEP_TIE = 1'b0 & (BEEP_SECS != 0);

    assign div_en = (state == ST_RUN);
    assign beep   = BEEP_TIE;
`endif

    divisor_1hz #(
        .CLK_HZ (CLK_HZ)
    ) u_divisor_1hz (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .clr   (div_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tm      <= TIME_ZERO;
            heating <= 1'b0;
            done    <= 1'b0;
`ifdef TEMPORIZADOR_BEEP_EN
            beep_q   <= 1'b0;
            beep_cnt <= '0;
`endif
        end else if (clear) begin
            // clear dominates everything, including a coincident tick
            state   <= ST_IDLE;
            tm      <= TIME_ZERO;
            heating <= 1'b0;
            done    <= 1'b0;
`ifdef TEMPORIZADOR_BEEP_EN
            beep_q   <= 1'b0;
            beep_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_from_idle) begin
                        state   <= ST_RUN;
                        heating <= 1'b1;
                    end else if (digit_accept) begin
                        tm <= bcd_shift_in(tm, digit);
                    end
                end

                ST_RUN: begin
                    // Pausing discards any tick landing in the same cycle.
                    if (stop || !door_closed) begin
                        state   <= ST_PAUSE;
                        heating <= 1'b0;
                    end else if (tick) begin
                        tm <= tm_dec;
                        if (tm_dec == TIME_ZERO) begin
                            state   <= ST_DONE;
                            heating <= 1'b0;
                            done    <= 1'b1;
`ifdef TEMPORIZADOR_BEEP_EN
                            beep_q   <= 1'b1;
                            beep_cnt <= '0;
`endif
                        end
                    end
                end

                ST_PAUSE: begin
                    if (!stop && start && door_closed) begin
                        state   <= ST_RUN;
                        heating <= 1'b1;
                    end
                end

                ST_DONE: begin
`ifdef TEMPORIZADOR_BEEP_EN
                    // tick only fires here while beep_q is high
                    if (tick) begin
                        if (beep_cnt == BEEP_LAST) begin
                            beep_q <= 1'b0;
                        end else begin
                            beep_cnt <= beep_cnt + 1'b1;
                        end
                    end
`endif
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mins     = tm.mins;
    assign sec_tens = tm.sec_tens;
    assign sec_ones = tm.sec_ones;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_temporizador_bcd
// Description : Self-checking bench for temporizador_bcd at CLK_HZ=10.
//               A seconds-based reference model is compared with the DUT on
//               every falling edge; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temporizador_bcd;

    localparam int HZ     = 10;
    localparam int BEEP_S = 3;
`ifdef TEMPORIZADOR_BEEP_EN
    localparam int BEEP_ON = 1;
`else
    localparam int BEEP_ON = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic [3:0] digit       = 4'd0;
    logic       digit_valid = 1'b0;
    logic       start       = 1'b0;
    logic       stop        = 1'b0;
    logic       clear       = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       heating;
    logic       done;
    logic       beep;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    temporizador_bcd #(
        .CLK_HZ    (HZ),
        .BEEP_SECS (BEEP_S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .heating     (heating),
        .done        (done),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: remaining time in whole seconds ----
    int m_state     = M_IDLE;
    int m_secs      = 0;
    int m_phase     = 0;
    int m_beep_left = 0;

    task automatic model_step();
        bit run_en;
        bit tk;
        run_en = (m_state == M_RUN) || (BEEP_ON == 1 && m_state == M_DONE && m_beep_left > 0);
        tk     = run_en && (m_phase == HZ - 1);
        if (run_en) m_phase = tk ? 0 : m_phase + 1;
        if (clear) begin
            m_state = M_IDLE; m_secs = 0; m_phase = 0; m_beep_left = 0;
        end else begin
            case (m_state)
                M_IDLE: if (!stop) begin
                    if (start) begin
                        if (door_closed && m_secs > 0) begin
                            m_state = M_RUN;
                            m_phase = 0;
                        end
                    end else if (digit_valid && digit <= 4'd9 && (m_secs % 10) <= 5) begin
                        // new M:SS = old tens : old ones, digit
                        m_secs = ((m_secs % 60) / 10) * 60 + (m_secs % 10) * 10 + int'(digit);
                    end
                end
                M_RUN: begin
                    if (stop || !door_closed) m_state = M_PAUSE;
                    else if (tk) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_state     = M_DONE;
                            m_beep_left = BEEP_ON * BEEP_S;
                        end
                    end
                end
                M_PAUSE: if (!stop && start && door_closed) m_state = M_RUN;
                default: if (tk) m_beep_left = m_beep_left - 1;
            endcase
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_secs = 0; m_phase = 0; m_beep_left = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_mins",     int'(mins),     m_secs / 60);
            chk("model_sec_tens", int'(sec_tens), (m_secs % 60) / 10);
            chk("model_sec_ones", int'(sec_ones), m_secs % 10);
            chk("model_heating",  int'(heating),  int'(m_state == M_RUN));
            chk("model_done",     int'(done),     int'(m_state == M_DONE));
            chk("model_beep",     int'(beep),     int'(m_beep_left > 0));
        end
    end

    // ---------------- stimulus helpers (inputs change on falling edges) ---
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        @(negedge clk);
        digit = d; digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    // 0 = start, 1 = stop, 2 = clear
    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0:       start = 1'b1;
            1:       stop  = 1'b1;
            default: clear = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic chk_time(input string name, input int m, input int t, input int o);
        chk({name, "_mins"}, int'(mins),     m);
        chk({name, "_tens"}, int'(sec_tens), t);
        chk({name, "_ones"}, int'(sec_ones), o);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int beep_cycles;
        int k;

        // reset
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        wait_neg(2);
        chk_time("reset", 0, 0, 0);
        chk("reset_heating", int'(heating), 0);
        chk("reset_done",    int'(done),    0);
        chk("reset_beep",    int'(beep),    0);
        rst_n = 1'b1;

        // digit entry and asynchronous reset mid-entry
        key(4'd1); key(4'd3); key(4'd0);
        chk_time("entry_130", 1, 3, 0);
        key(4'd2);
        chk_time("entry_302", 3, 0, 2);
        #2 rst_n = 1'b0;
        #1 chk_time("async_reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // countdown across a minute
        key(4'd1); key(4'd3); key(4'd0);
        door_closed = 1'b1;
        pulse(0);
        chk("run_heating", int'(heating), 1);
        wait_neg(10);
        chk_time("cnt_129", 1, 2, 9);
        wait_neg(300);
        chk_time("cnt_059", 0, 5, 9);
        wait_neg(589);
        chk("cnt_899_done", int'(done), 0);
        chk_time("cnt_899", 0, 0, 1);
        wait_neg(1);
        chk("cnt_900_done",    int'(done),    1);
        chk("cnt_900_heating", int'(heating), 0);
        chk_time("cnt_900", 0, 0, 0);
        pulse(2);

        // door open mid-run, resume honouring partial second
        key(4'd1); key(4'd0); key(4'd0);
        chk_time("entry_100", 1, 0, 0);
        pulse(0);
        wait_neg(153);
        chk_time("door_045", 0, 4, 5);
        door_closed = 1'b0;
        wait_neg(1);
        chk("door_heating", int'(heating), 0);
        wait_neg(20);
        chk_time("door_hold", 0, 4, 5);
        door_closed = 1'b1;
        pulse(0);
        chk("resume_heating", int'(heating), 1);
        wait_neg(5);
        chk_time("resume_r5", 0, 4, 5);
        wait_neg(1);
        chk_time("resume_r6", 0, 4, 4);

        // clear coincident with tick
        wait_neg(9);
        chk_time("pre_clear", 0, 4, 4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_time("clear_tick", 0, 0, 0);
        chk("clear_heating", int'(heating), 0);
        chk("clear_done",    int'(done),    0);

        // rejected start and entries
        pulse(0);
        chk("zero_start", int'(heating), 0);
        wait_neg(3);
        chk("zero_start_hold", int'(heating), 0);
        key(4'd7); key(4'd0);
        chk_time("reject_07", 0, 0, 7);
        pulse(2);
        key(4'd2); key(4'hC);
        chk_time("reject_hexC", 0, 0, 2);

        // stop/resume then completion and beep window
        pulse(2);
        key(4'd3);
        pulse(0);
        wait_neg(12);
        pulse(1);
        chk("stop_heating", int'(heating), 0);
        wait_neg(5);
        chk_time("stop_hold", 0, 0, 2);
        pulse(0);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", int'(done), 1);
        beep_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (beep) beep_cycles++;
            @(negedge clk);
        end
        chk("beep_cycles", beep_cycles, BEEP_ON * BEEP_S * HZ);

        // DONE ignores digits and start
        key(4'd5);
        pulse(0);
        chk("done_hold", int'(done), 1);
        chk_time("done_hold", 0, 0, 0);
        pulse(2);
        chk("done_cleared", int'(done), 0);

        wait_neg(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
